smg_display_arbiter: RTL and testbench

Owns the 4-digit seven-segment display and shares it between three requesters, for example PC, register-file probe and memory-data probe. It round-robin grants the display to one requester for a minimum dwell time and shows that requester's 16-bit value as four hex digits. It generates the 1 ms digit-scan strobe and the registered segment patterns. It sits between the CPU debug taps and the board's display pins.

---
 rtl/smg_display_arbiter.sv | 150 +++++++++++++++
 tb/tb_smg_display_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smg_display_arbiter.sv
// smg_display_arbiter
// Shares a 4-digit common-anode seven-segment display between three requesters.
// A round-robin arbiter grants the display for DWELL scan ticks; the granted
// requester's 16-bit value is shown as four hex digits, scanned at one digit
// per tick (T1MS+1 clock cycles).
//
// Ports
//   CLK       system clock, rising edge
//   RST       asynchronous active-high reset
//   Req[2:0]  level requests
//   Data0..2  16-bit values to display, one per requester
//   Gnt[2:0]  one-hot grant, 3'b000 when idle
//   Scan_Sig  digit enables, active-low, [3] = leftmost digit
//   Seg_Sig   segments, active-low, [7]=dp, [6:0]=g..a
module smg_display_arbiter #(
  parameter logic [16:0] T1MS  = 17'd99999,
  parameter logic [15:0] DWELL = 16'd1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  Req,
  input  logic [15:0] Data0,
  input  logic [15:0] Data1,
  input  logic [15:0] Data2,
  output logic [2:0]  Gnt,
  output logic [3:0]  Scan_Sig,
  output logic [7:0]  Seg_Sig
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state, state_nxt;
  logic [16:0] c1;
  logic        tick;
  logic [1:0]  idx;
  logic [15:0] d, d_nxt;
  logic [1:0]  last, last_nxt;
  logic [2:0]  gnt_nxt;
  logic [15:0] disp;
  logic        shown;
  logic [1:0]  p1, p2, winner;
  logic [15:0] gdata;
  logic [3:0]  nib;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign tick = (c1 == T1MS);

  // Search last+1, last+2, then last itself so a lone requester can be regranted.
  always_comb begin
    p1 = inc3(last);
    p2 = inc3(p1);
    if (Req[p1])      winner = p1;
    else if (Req[p2]) winner = p2;
    else              winner = last;
  end

  always_comb begin
    case (Gnt)
      3'b001:  gdata = Data0;
      3'b010:  gdata = Data1;
      3'b100:  gdata = Data2;
      default: gdata = disp;
    endcase
  end

  always_comb begin
    case (idx)
      2'd0:    nib = disp[15:12];
      2'd1:    nib = disp[11:8];
      2'd2:    nib = disp[7:4];
      default: nib = disp[3:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = Gnt;
    d_nxt     = d;
    last_nxt  = last;
    case (state)
      IDLE: if (|Req) begin
        gnt_nxt   = 3'b001 << winner;
        last_nxt  = winner;
        d_nxt     = 16'd0;
        state_nxt = HOLD;
      end
      default: if (tick) begin
        if (d == DWELL - 16'd1) begin
          d_nxt = 16'd0;
          if (|Req) begin
            gnt_nxt  = 3'b001 << winner;
            last_nxt = winner;
          end else begin
            gnt_nxt   = 3'b000;
            state_nxt = IDLE;
          end
        end else begin
          d_nxt = d + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      Gnt      <= 3'b000;
      d        <= 16'd0;
      last     <= 2'd2;
      c1       <= 17'd0;
      idx      <= 2'd0;
      disp     <= 16'd0;
      shown    <= 1'b0;
      Scan_Sig <= 4'b1111;
      Seg_Sig  <= 8'hFF;
    end else begin
      state <= state_nxt;
      Gnt   <= gnt_nxt;
      d     <= d_nxt;
      last  <= last_nxt;
      c1    <= tick ? 17'd0 : c1 + 17'd1;
      if (tick) idx <= idx + 2'd1;
      // Live view of the granted value; shown only goes high once real data is in disp.
      if (state == HOLD) begin
        disp  <= gdata;
        shown <= 1'b1;
      end
      // Scan and segments come from the same idx/disp so they switch together.
      Scan_Sig <= ~(4'b1000 >> idx);
      Seg_Sig  <= shown ? {1'b1, seg7(nib)} : 8'hFF;
    end
  end

endmodule

// File: tb/tb_smg_display_arbiter.sv
module tb_smg_display_arbiter;

  localparam int T1MS  = 3;
  localparam int DWELL = 2;

  logic        CLK, RST;
  logic [2:0]  Req;
  logic [15:0] Data0, Data1, Data2;
  logic [2:0]  Gnt;
  logic [3:0]  Scan_Sig;
  logic [7:0]  Seg_Sig;

  int n_cmp, n_bad;

  smg_display_arbiter #(.T1MS(17'd3), .DWELL(16'd2)) dut (
    .CLK(CLK), .RST(RST), .Req(Req), .Data0(Data0), .Data1(Data1), .Data2(Data2),
    .Gnt(Gnt), .Scan_Sig(Scan_Sig), .Seg_Sig(Seg_Sig)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: time measured in cycles since reset release, grant tracked
  // as "owner + ticks remaining".
  int          cyc, m_g, m_left, m_last;
  logic [15:0] m_disp;
  bit          m_shown;
  logic [2:0]  e_gnt;
  logic [3:0]  e_scan;
  logic [7:0]  e_seg;

  function automatic logic [6:0] hexseg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic int pick(input int lst, input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      automatic int c = (lst + k) % 3;
      if (r[c]) return c;
    end
    return lst;
  endfunction

  function automatic logic [15:0] data_of(input int g);
    if (g == 0) return Data0;
    if (g == 1) return Data1;
    return Data2;
  endfunction

  // Digit shown at a given scan position (0 = leftmost) of a 16-bit value.
  function automatic logic [3:0] digit_of(input logic [15:0] v, input int pos);
    logic [15:0] s;
    s = v >> (12 - 4 * pos);
    return s[3:0];
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      cyc <= 0; m_g <= -1; m_left <= 0; m_last <= 2; m_disp <= 16'h0; m_shown <= 1'b0;
      e_gnt <= 3'b000; e_scan <= 4'b1111; e_seg <= 8'hFF;
    end else begin
      automatic int di   = (cyc / (T1MS + 1)) % 4;
      automatic bit tk   = (cyc % (T1MS + 1)) == T1MS;
      automatic int g    = m_g;
      automatic int left = m_left;
      e_scan <= ~(4'b1000 >> di);
      e_seg  <= m_shown ? {1'b1, hexseg(digit_of(m_disp, di))} : 8'hFF;
      if (m_g >= 0) begin
        m_disp  <= data_of(m_g);
        m_shown <= 1'b1;
      end
      if (g < 0) begin
        if (Req != 3'b000) begin g = pick(m_last, Req); left = DWELL; end
      end else if (tk) begin
        left = left - 1;
        if (left == 0) begin
          if (Req != 3'b000) begin g = pick(m_last, Req); left = DWELL; end
          else g = -1;
        end
      end
      m_g <= g;
      m_left <= left;
      if (g >= 0) m_last <= g;
      e_gnt <= (g < 0) ? 3'b000 : (3'b001 << g);
      cyc <= cyc + 1;
    end
  end

  task automatic do_reset(input logic [2:0] req_after);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    Req = req_after;
    RST = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; Req = 3'b000;
    Data0 = 16'(($urandom)); Data1 = 16'(($urandom)); Data2 = 16'(($urandom));
    #12;
    n_cmp++;
    if ({Gnt, Scan_Sig, Seg_Sig} !== {3'b000, 4'b1111, 8'hFF}) begin
      n_bad++;
      $display("FAIL reset_values got gnt=%b scan=%b seg=%h need 000/1111/ff", Gnt, Scan_Sig, Seg_Sig);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (Scan_Sig !== 4'b0111) begin
      n_bad++;
      $display("FAIL reset_first_scan got %b need 0111", Scan_Sig);
    end
    for (int i = 1; i < 20; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (Scan_Sig !== ~(4'b1000 >> ((i / 4) % 4)) || Seg_Sig !== 8'hFF || Gnt !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_scan cyc=%0d got scan=%b seg=%h gnt=%b", i, Scan_Sig, Seg_Sig, Gnt);
      end
    end
  endtask

  task automatic test_single_req;
    logic [7:0] want;
    Data1 = 16'h12AF; Data0 = 16'(($urandom)); Data2 = 16'(($urandom));
    Req = 3'b010;
    @(negedge CLK);
    n_cmp++;
    if (Gnt !== 3'b010) begin
      n_bad++;
      $display("FAIL single_latency got gnt=%b need 010", Gnt);
    end
    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      case (Scan_Sig)
        4'b0111: want = 8'hF9;
        4'b1011: want = 8'hA4;
        4'b1101: want = 8'h88;
        default: want = 8'h8E;
      endcase
      if (i >= 2) begin
        n_cmp++;
        if (Seg_Sig !== want || Gnt !== 3'b010) begin
          n_bad++;
          $display("FAIL single_digits scan=%b got seg=%h gnt=%b need seg=%h gnt=010", Scan_Sig, Seg_Sig, Gnt, want);
        end
      end
      n_cmp++;
      if ({Gnt, Scan_Sig, Seg_Sig} !== {e_gnt, e_scan, e_seg}) begin
        n_bad++;
        $display("FAIL single_model got %b/%b/%h need %b/%b/%h", Gnt, Scan_Sig, Seg_Sig, e_gnt, e_scan, e_seg);
      end
    end
    Req = 3'b000;
  endtask

  task automatic test_round_robin;
    logic [2:0] seq[$];
    logic [2:0] prev;
    do_reset(3'b111);
    prev = 3'b000;
    for (int i = 0; i < 120; i++) begin
      @(negedge CLK);
      Data0 = 16'(($urandom)); Data1 = 16'(($urandom)); Data2 = 16'(($urandom));
      if (Gnt !== prev) begin
        if (Gnt !== 3'b000) seq.push_back(Gnt);
        n_cmp++;
        if (Gnt === 3'b000) begin
          n_bad++;
          $display("FAIL rr_gap cyc=%0d got gnt=000 need nonzero", i);
        end
        prev = Gnt;
      end
      n_cmp++;
      if ({Gnt, Scan_Sig, Seg_Sig} !== {e_gnt, e_scan, e_seg}) begin
        n_bad++;
        $display("FAIL rr_model got %b/%b/%h need %b/%b/%h", Gnt, Scan_Sig, Seg_Sig, e_gnt, e_scan, e_seg);
      end
    end
    n_cmp++;
    if (seq.size() < 4) begin
      n_bad++;
      $display("FAIL rr_count got %0d grants need >=4", seq.size());
    end else if (seq[0] !== 3'b001 || seq[1] !== 3'b010 || seq[2] !== 3'b100 || seq[3] !== 3'b001) begin
      n_bad++;
      $display("FAIL rr_order got %b %b %b %b need 001 010 100 001", seq[0], seq[1], seq[2], seq[3]);
    end
    Req = 3'b000;
  endtask

  task automatic test_pulse;
    logic [15:0] v;
    bit seen_g, seen_z;
    logic [7:0] want;
    do_reset(3'b000);
    v = 16'(($urandom));
    @(negedge CLK);
    Data1 = v; Req = 3'b010;
    @(negedge CLK);
    Req = 3'b000;
    seen_g = 1'b0; seen_z = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Gnt === 3'b010) seen_g = 1'b1;
      if (Gnt === 3'b000 && seen_g) seen_z = 1'b1;
      n_cmp++;
      if ((seen_z && Gnt !== 3'b000) || (!seen_z && Gnt !== 3'b010)) begin
        n_bad++;
        $display("FAIL pulse_hold cyc=%0d got gnt=%b expired=%0d", i, Gnt, seen_z);
      end
      if (seen_z) Data1 = 16'(($urandom));
      @(negedge CLK);
      if (seen_z) begin
        want = {1'b1, hexseg(digit_of(v, (Scan_Sig == 4'b0111) ? 0 : (Scan_Sig == 4'b1011) ? 1 :
                                        (Scan_Sig == 4'b1101) ? 2 : 3))};
        n_cmp++;
        if (Seg_Sig !== want) begin
          n_bad++;
          $display("FAIL pulse_frozen scan=%b got seg=%h need %h", Scan_Sig, Seg_Sig, want);
        end
      end
      n_cmp++;
      if ({Gnt, Scan_Sig, Seg_Sig} !== {e_gnt, e_scan, e_seg}) begin
        n_bad++;
        $display("FAIL pulse_model got %b/%b/%h need %b/%b/%h", Gnt, Scan_Sig, Seg_Sig, e_gnt, e_scan, e_seg);
      end
    end
    n_cmp++;
    if (!seen_z) begin
      n_bad++;
      $display("FAIL pulse_expiry got gnt=%b never released need 000", Gnt);
    end
  endtask

  task automatic test_live_update;
    logic [7:0] want;
    Data2 = 16'h0000;
    do_reset(3'b100);
    for (int i = 0; i < 5; i++) @(negedge CLK);
    Data2 = 16'hE0E0;
    @(negedge CLK);
    @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      want = (Scan_Sig == 4'b0111 || Scan_Sig == 4'b1101) ? 8'h86 : 8'hC0;
      n_cmp++;
      if (Seg_Sig !== want || Gnt !== 3'b100) begin
        n_bad++;
        $display("FAIL live_update scan=%b got seg=%h gnt=%b need seg=%h gnt=100", Scan_Sig, Seg_Sig, Gnt, want);
      end
      n_cmp++;
      if ({Gnt, Scan_Sig, Seg_Sig} !== {e_gnt, e_scan, e_seg}) begin
        n_bad++;
        $display("FAIL live_model got %b/%b/%h need %b/%b/%h", Gnt, Scan_Sig, Seg_Sig, e_gnt, e_scan, e_seg);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid;
    Req = 3'b001;
    for (int i = 0; i < 24; i++) @(negedge CLK);
    n_cmp++;
    if (Gnt !== 3'b001) begin
      n_bad++;
      $display("FAIL mid_setup got gnt=%b need 001", Gnt);
    end
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if ({Gnt, Scan_Sig, Seg_Sig} !== {3'b000, 4'b1111, 8'hFF}) begin
      n_bad++;
      $display("FAIL mid_reset got %b/%b/%h need 000/1111/ff", Gnt, Scan_Sig, Seg_Sig);
    end
    @(negedge CLK);
    Req = 3'b111;
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (Gnt !== 3'b001) begin
      n_bad++;
      $display("FAIL mid_first_winner got gnt=%b need 001", Gnt);
    end
  endtask

  task automatic test_random;
    do_reset(3'(($urandom)));
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ({Gnt, Scan_Sig, Seg_Sig} !== {e_gnt, e_scan, e_seg}) begin
        n_bad++;
        $display("FAIL random_model cyc=%0d got %b/%b/%h need %b/%b/%h", i, Gnt, Scan_Sig, Seg_Sig, e_gnt, e_scan, e_seg);
      end
      if ($urandom_range(7) == 0) Req = 3'(($urandom));
      if ($urandom_range(3) == 0) Data0 = 16'(($urandom));
      if ($urandom_range(3) == 0) Data1 = 16'(($urandom));
      if ($urandom_range(3) == 0) Data2 = 16'(($urandom));
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    test_reset;
    test_single_req;
    test_round_robin;
    test_pulse;
    test_live_update;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
